// File: rtl/id_stage_pipe.sv
// Decode stage with ID/EX register; optional write-back bypass via ID_WB_BYPASS_EN.
// Latency: 1 cycle from accept to out_valid_o.
// Backpressure: bundle held while out_valid_o & ~out_ready_i; in_ready_o drops on stall, load-use hazard or flush.
module id_stage_pipe #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int GPR_AW = 5,
    parameter int ID_LEN = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       instr_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    output logic [GPR_AW-1:0] rs1_addr_o,
    output logic [GPR_AW-1:0] rs2_addr_o,
    output logic [6:0]        funct7_o,
    output logic [2:0]        funct3_o,
    output logic [6:0]        opcode_o,
    input  logic [4:0]        ctrl_i,
    input  logic [ID_LEN-1:0] instr_id_i,
    input  logic [XLEN-1:0]   rs1_val_i,
    input  logic [XLEN-1:0]   rs2_val_i,
    input  logic              wb_we_i,
    input  logic [GPR_AW-1:0] wb_addr_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [GPR_AW-1:0] rd_addr_o,
    output logic [GPR_AW-1:0] rs1_addr_q_o,
    output logic [GPR_AW-1:0] rs2_addr_q_o,
    output logic [4:0]        ctrl_o,
    output logic [ID_LEN-1:0] instr_id_o,
    output logic [XLEN-1:0]   rs1_val_o,
    output logic [XLEN-1:0]   rs2_val_o,
    output logic [XLEN-1:0]   imm_o
);

    typedef struct packed {
        logic rs1_re;
        logic rs2_re;
        logic rd_we;
        logic mem_re;
        logic mem_we;
    } ctrl_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [GPR_AW-1:0] rd_addr;
        logic [GPR_AW-1:0] rs1_addr;
        logic [GPR_AW-1:0] rs2_addr;
        ctrl_t             ctrl;
        logic [ID_LEN-1:0] instr_id;
        logic [XLEN-1:0]   rs1_val;
        logic [XLEN-1:0]   rs2_val;
        logic [XLEN-1:0]   imm;
    } bundle_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    ctrl_t              ctrl_dec;
    bundle_t            bundle_q;
    bundle_t            bundle_d;
    logic               out_valid_q;
    logic               hazard;
    logic               accept;
    logic signed [31:0] imm32;
    logic [XLEN-1:0]    rs1_val_d;
    logic [XLEN-1:0]    rs2_val_d;

    assign rs1_addr_o = GPR_AW'(instr_i[19:15]);
    assign rs2_addr_o = GPR_AW'(instr_i[24:20]);
    assign funct7_o   = instr_i[31:25];
    assign funct3_o   = instr_i[14:12];
    assign opcode_o   = instr_i[6:0];
    assign ctrl_dec   = ctrl_t'(ctrl_i);

    // Immediates are assembled at 32 bits, then sign-extended to XLEN by the signed cast.
    always_comb begin
        imm32 = '0;
        case (instr_i[6:0])
            OP_IMM, OP_LOAD, OP_JALR:
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            OP_STORE:
                imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            OP_BRANCH:
                imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                         instr_i[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm32 = {instr_i[31:12], 12'b0};
            OP_JAL:
                imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                         instr_i[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

`ifdef ID_WB_BYPASS_EN
    // Write-back lands in the regfile at this edge, so its read port still shows the old value.
    assign rs1_val_d = (wb_we_i && (wb_addr_i != '0) && (wb_addr_i == rs1_addr_o)) ?
                       wb_data_i : rs1_val_i;
    assign rs2_val_d = (wb_we_i && (wb_addr_i != '0) && (wb_addr_i == rs2_addr_o)) ?
                       wb_data_i : rs2_val_i;
`else
    logic wb_unused;
    assign wb_unused = ^{wb_we_i, wb_addr_i, wb_data_i};
    assign rs1_val_d = rs1_val_i;
    assign rs2_val_d = rs2_val_i;
`endif

    always_comb begin
        bundle_d          = '0;
        bundle_d.pc       = pc_i;
        bundle_d.rd_addr  = GPR_AW'(instr_i[11:7]);
        bundle_d.rs1_addr = rs1_addr_o;
        bundle_d.rs2_addr = rs2_addr_o;
        bundle_d.ctrl     = ctrl_dec;
        bundle_d.instr_id = instr_id_i;
        bundle_d.rs1_val  = rs1_val_d;
        bundle_d.rs2_val  = rs2_val_d;
        bundle_d.imm      = XLEN'(imm32);
    end

    // Load in EXE whose result the decoding instruction needs: hold it in IF/ID for one bubble.
    assign hazard = out_valid_q && bundle_q.ctrl.mem_re && (bundle_q.rd_addr != '0) &&
                    ((ctrl_dec.rs1_re && (rs1_addr_o == bundle_q.rd_addr)) ||
                     (ctrl_dec.rs2_re && (rs2_addr_o == bundle_q.rd_addr)));

    assign in_ready_o = (!out_valid_q || out_ready_i) && !hazard && !flush_i;
    assign accept     = in_valid_i && in_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            bundle_q    <= bundle_d;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign pc_o         = bundle_q.pc;
    assign rd_addr_o    = bundle_q.rd_addr;
    assign rs1_addr_q_o = bundle_q.rs1_addr;
    assign rs2_addr_q_o = bundle_q.rs2_addr;
    assign ctrl_o       = bundle_q.ctrl;
    assign instr_id_o   = bundle_q.instr_id;
    assign rs1_val_o    = bundle_q.rs1_val;
    assign rs2_val_o    = bundle_q.rs2_val;
    assign imm_o        = bundle_q.imm;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: immediates, load-use bubble, backpressure, flush, bypass.
module tb_id_stage_pipe;

    localparam logic [4:0] C_ALU_I = 5'b10100;
    localparam logic [4:0] C_ALU_R = 5'b11100;
    localparam logic [4:0] C_LOAD  = 5'b10110;
    localparam logic [4:0] C_STORE = 5'b11001;
    localparam logic [4:0] C_BR    = 5'b11000;
    localparam logic [4:0] C_JUMP  = 5'b00100;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        flush;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [6:0]  funct7, opcode;
    logic [2:0]  funct3;
    logic [4:0]  ctrl;
    logic [5:0]  instr_id;
    logic [31:0] rs1_val, rs2_val;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc_q;
    logic [4:0]  rd_q, rs1_q, rs2_q;
    logic [4:0]  ctrl_q;
    logic [5:0]  instr_id_q;
    logic [31:0] rs1_val_q, rs2_val_q, imm_q;

    int checks   = 0;
    int failures = 0;
    logic [31:0] bypass_exp;

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .instr_i      (instr),
        .pc_i         (pc),
        .flush_i      (flush),
        .rs1_addr_o   (rs1_addr),
        .rs2_addr_o   (rs2_addr),
        .funct7_o     (funct7),
        .funct3_o     (funct3),
        .opcode_o     (opcode),
        .ctrl_i       (ctrl),
        .instr_id_i   (instr_id),
        .rs1_val_i    (rs1_val),
        .rs2_val_i    (rs2_val),
        .wb_we_i      (wb_we),
        .wb_addr_i    (wb_addr),
        .wb_data_i    (wb_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .pc_o         (pc_q),
        .rd_addr_o    (rd_q),
        .rs1_addr_q_o (rs1_q),
        .rs2_addr_q_o (rs2_q),
        .ctrl_o       (ctrl_q),
        .instr_id_o   (instr_id_q),
        .rs1_val_o    (rs1_val_q),
        .rs2_val_o    (rs2_val_q),
        .imm_o        (imm_q)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] p, input logic [4:0] c,
                         input logic rdy);
        in_valid  = 1'b1;
        instr     = ins;
        pc        = p;
        ctrl      = c;
        instr_id  = ins[12:7];
        out_ready = rdy;
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; instr = '0; pc = '0; flush = 1'b0; ctrl = '0;
        instr_id = '0; rs1_val = '0; rs2_val = '0; wb_we = 1'b0; wb_addr = '0;
        wb_data = '0; out_ready = 1'b1;
        bypass_exp = 32'h0;
        tick();
        tick();
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_imm", 64'(imm_q), 64'h0);
        check("rst_pc", 64'(pc_q), 64'h0);
        rst = 1'b0;
        #1;
        check("rdy_after_rst", 64'(in_ready), 64'h1);

        // addi x1,x0,-1 : field split and I immediate
        drive(32'hFFF00093, 32'h1000, C_ALU_I, 1'b1);
        check("opcode", 64'(opcode), 64'h13);
        check("funct7", 64'(funct7), 64'h7F);
        check("rs2_addr", 64'(rs2_addr), 64'h1F);
        tick();
        check("addi_valid", 64'(out_valid), 64'h1);
        check("addi_imm", 64'(imm_q), 64'hFFFF_FFFF);
        check("addi_pc", 64'(pc_q), 64'h1000);
        check("addi_rd", 64'(rd_q), 64'h1);
        check("addi_id", 64'(instr_id_q), 64'h01);

        drive(32'hFE112E23, 32'h1004, C_STORE, 1'b1);
        tick();
        check("sw_imm", 64'(imm_q), 64'hFFFF_FFFC);
        drive(32'hFE000EE3, 32'h1008, C_BR, 1'b1);
        tick();
        check("beq_imm", 64'(imm_q), 64'hFFFF_FFFC);
        drive(32'h0080006F, 32'h100C, C_JUMP, 1'b1);
        tick();
        check("jal_imm", 64'(imm_q), 64'h8);
        drive(32'h123450B7, 32'h1010, C_JUMP, 1'b1);
        tick();
        check("lui_imm", 64'(imm_q), 64'h1234_5000);
        drive(32'h00128333, 32'h1014, C_ALU_R, 1'b1);
        tick();
        check("add_imm", 64'(imm_q), 64'h0);
        check("add_rs1q", 64'(rs1_q), 64'h5);
        check("add_rs2q", 64'(rs2_q), 64'h1);

        // load-use: lw x5 then add x6,x5,x1
        drive(32'h0000A283, 32'h1018, C_LOAD, 1'b1);
        tick();
        check("lw_ctrl", 64'(ctrl_q), 64'(C_LOAD));
        drive(32'h00128333, 32'h101C, C_ALU_R, 1'b1);
        check("lu_rdy_low", 64'(in_ready), 64'h0);
        tick();
        check("lu_bubble", 64'(out_valid), 64'h0);
        check("lu_rdy_back", 64'(in_ready), 64'h1);
        tick();
        check("lu_add_valid", 64'(out_valid), 64'h1);
        check("lu_add_pc", 64'(pc_q), 64'h101C);
        check("lu_add_rd", 64'(rd_q), 64'h6);

        // backpressure: A held three cycles while B waits
        drive(32'h00000013, 32'h0100, C_ALU_I, 1'b1);
        tick();
        drive(32'h00200093, 32'h0104, C_ALU_I, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("bp_rdy_low", 64'(in_ready), 64'h0);
            tick();
            check("bp_valid", 64'(out_valid), 64'h1);
            check("bp_pc_held", 64'(pc_q), 64'h0100);
            check("bp_imm_held", 64'(imm_q), 64'h0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_rdy_release", 64'(in_ready), 64'h1);
        tick();
        check("bp_b_pc", 64'(pc_q), 64'h0104);
        check("bp_b_imm", 64'(imm_q), 64'h2);
        in_valid = 1'b0;
        tick();
        check("bp_no_dup", 64'(out_valid), 64'h0);

        // flush kills held and incoming
        drive(32'h00000013, 32'h0200, C_ALU_I, 1'b1);
        tick();
        check("fl_pre_valid", 64'(out_valid), 64'h1);
        drive(32'h00300093, 32'h0204, C_ALU_I, 1'b1);
        flush = 1'b1;
        #1;
        check("fl_rdy_low", 64'(in_ready), 64'h0);
        tick();
        check("fl_valid", 64'(out_valid), 64'h0);
        check("fl_pc_kept", 64'(pc_q), 64'h0200);
        flush = 1'b0;
        in_valid = 1'b0;

        // load to x0 must not stall a reader of x0
        drive(32'h00008003, 32'h0300, C_LOAD, 1'b1);
        tick();
        drive(32'h00000333, 32'h0304, C_ALU_R, 1'b1);
        check("x0_no_hazard", 64'(in_ready), 64'h1);
        tick();
        check("x0_pc", 64'(pc_q), 64'h0304);

        // write-back in the same cycle as add x4,x3,x3
`ifdef ID_WB_BYPASS_EN
        bypass_exp = 32'hDEAD_BEEF;
`endif
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD_BEEF;
        rs1_val = 32'h0; rs2_val = 32'h0;
        drive(32'h00318233, 32'h0308, C_ALU_R, 1'b1);
        tick();
        check("byp_rs1", 64'(rs1_val_q), 64'(bypass_exp));
        check("byp_rs2", 64'(rs2_val_q), 64'(bypass_exp));
        wb_addr = 5'd0; wb_data = 32'h0000_0BAD;
        rs1_val = 32'h11; rs2_val = 32'h22;
        drive(32'h00318233, 32'h030C, C_ALU_R, 1'b1);
        tick();
        check("nobyp_rs1", 64'(rs1_val_q), 64'h11);
        check("nobyp_rs2", 64'(rs2_val_q), 64'h22);
        in_valid = 1'b0;
        wb_we = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
